// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame FSM with timeout, FWFT scancode FIFO.
// Optional E0/F0 prefix folding into data_ext/data_brk when PS2_PREFIX_DECODE_EN is defined.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_LEN       = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk_50,
    input  logic                          rstn,
    input  logic                          kb_clk,
    input  logic                          kb_data,
    output logic [7:0]                    data_out,
    output logic                          data_ext,
    output logic                          data_brk,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int FCNT_W = $clog2(FILT_LEN + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
`ifdef PS2_PREFIX_DECODE_EN
    localparam int ENTRY_W = 10;
`else
    localparam int ENTRY_W = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_s, dat_s;
    logic                   filt_q, filt_d, fall_q;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;

    always_ff @(posedge clk_50 or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], kb_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kb_data};
        end
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // Filtered clock flips on the FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FILT_LAST) filt_d = clk_s;
            else                     fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge rstn) begin
        if (!rstn) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end

    state_t            state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              ferr_q, ferr_d;
    logic              emit_vld_q, emit_vld_d;
    logic [7:0]        emit_byte_q, emit_byte_d;

    // timer_q holds the number of cycles since the last accepted falling edge.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        ferr_d      = 1'b0;
        emit_vld_d  = 1'b0;
        emit_byte_d = emit_byte_q;
        if (fall_q)                timer_d = TMR_W'(1);
        else if (state_q == S_IDLE) timer_d = '0;
        else                       timer_d = timer_q + 1'b1;

        if (fall_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d  = {dat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (dat_s && (^{shift_q, par_q})) begin
                        emit_vld_d  = 1'b1;
                        emit_byte_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && timer_q == TMR_LAST) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
            shift_d = '0;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk_50 or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            timer_q     <= '0;
            ferr_q      <= 1'b0;
            emit_vld_q  <= 1'b0;
            emit_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            timer_q     <= timer_d;
            ferr_q      <= ferr_d;
            emit_vld_q  <= emit_vld_d;
            emit_byte_q <= emit_byte_d;
        end
    end

    logic               push_vld;
    logic [ENTRY_W-1:0] push_entry;

`ifdef PS2_PREFIX_DECODE_EN
    logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push_vld   = 1'b0;
        push_entry = {ext_pend_q, brk_pend_q, emit_byte_q};
        if (ferr_q) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (emit_vld_q) begin
            if (emit_byte_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (emit_byte_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                push_vld   = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rstn) begin
        if (!rstn) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end
`else
    assign push_vld   = emit_vld_q;
    assign push_entry = emit_byte_q;
`endif

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               full, not_empty, pop, accept;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full      = (level_q == LVL_FULL);
        not_empty = (level_q != '0);
        pop       = not_empty & data_ready;
        accept    = push_vld & (~full | pop);
        ovf_d     = push_vld & full & ~pop;
        level_d   = level_q + LVL_W'(accept) - LVL_W'(pop);
    end

    always_ff @(posedge clk_50 or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_50) begin
        if (accept) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head       = mem_q[rd_ptr_q];
    assign data_valid = not_empty;
    assign data_out   = not_empty ? head[7:0] : 8'h00;
`ifdef PS2_PREFIX_DECODE_EN
    assign data_ext   = not_empty & head[9];
    assign data_brk   = not_empty & head[8];
`else
    assign data_ext   = 1'b0;
    assign data_brk   = 1'b0;
`endif
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule
